// File: rtl/toggle_event_gen_if.sv
// Bundles the monitored vector, its qualifiers and the coverage outputs
// that travel between the sampled design block and the toggle coverage reporter.
interface toggle_event_gen_if #(
  parameter int WIDTH = 28,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic [WIDTH-1:0] sig;
  logic             sample_en;
  logic             clear;
  logic [WIDTH-1:0] valid;
  logic [WIDTH-1:0] covered;
  logic [CNT_W-1:0] covered_count;
  logic             all_covered;

  modport master (
    output sig, sample_en, clear,
    input  valid, covered, covered_count, all_covered
  );

  modport slave (
    input  sig, sample_en, clear,
    output valid, covered, covered_count, all_covered
  );
endinterface

// File: rtl/toggle_event_gen.sv
// Per-bit toggle detector: a bit becomes covered once it has both risen and
// fallen since the epoch baseline, and is then reported exactly once.
module toggle_event_gen #(
  parameter int WIDTH = 28,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  toggle_event_gen_if.slave  bus
);

  logic [WIDTH-1:0] r_prev;
  logic             r_base_ok;
  logic [WIDTH-1:0] r_rose;
  logic [WIDTH-1:0] r_fell;
  logic [WIDTH-1:0] r_covered;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_valid;
  logic             r_all;

  logic [WIDTH-1:0] w_rose_nxt;
  logic [WIDTH-1:0] w_fell_nxt;
  logic [WIDTH-1:0] w_new;
  logic [CNT_W:0]   w_sum;

  function automatic logic [CNT_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [CNT_W:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s = s + {{CNT_W{1'b0}}, v[i]};
    end
    return s;
  endfunction

  // A bit can never be counted twice, so the extra sum bit never carries
  // into a value above WIDTH; it only keeps the all-covered compare exact.
  always_comb begin
    w_rose_nxt = r_rose | (bus.sig & ~r_prev);
    w_fell_nxt = r_fell | (~bus.sig & r_prev);
    w_new      = w_rose_nxt & w_fell_nxt & ~r_covered;
    w_sum      = {1'b0, r_count} + popcount(w_new);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev    <= '0;
      r_base_ok <= 1'b0;
      r_rose    <= '0;
      r_fell    <= '0;
      r_covered <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_all     <= 1'b0;
    end else if (bus.clear) begin
      // Clear wins over a same-edge sample; the next enabled sample rebaselines.
      r_base_ok <= 1'b0;
      r_rose    <= '0;
      r_fell    <= '0;
      r_covered <= '0;
      r_count   <= '0;
      r_valid   <= '0;
      r_all     <= 1'b0;
    end else if (bus.sample_en) begin
      r_prev <= bus.sig;
      if (!r_base_ok) begin
        r_base_ok <= 1'b1;
        r_valid   <= '0;
      end else begin
        r_rose    <= w_rose_nxt;
        r_fell    <= w_fell_nxt;
        r_valid   <= w_new;
        r_covered <= r_covered | w_new;
        r_count   <= w_sum[CNT_W-1:0];
        r_all     <= (w_sum == (CNT_W + 1)'(WIDTH));
      end
    end else begin
      r_valid <= '0;
    end
  end

  assign bus.valid         = r_valid;
  assign bus.covered       = r_covered;
  assign bus.covered_count = r_count;
  assign bus.all_covered   = r_all;

endmodule
